// File: rtl/iob_fir_seq.sv
// Time-multiplexed symmetric FIR: one pre-add/multiply/accumulate tap per cycle.
// Optional macro IOB_FIR_SEQ_SAT_EN: saturate data_out and add sticky sat_flag.
//
// state   | meaning
// IDLE    | waiting for a sample; coefficient writes accepted
// MAC     | one symmetric tap accumulated per cycle
// OUT     | result held on data_out until the sink takes it
module iob_fir_seq #(
  parameter int DATA_IN_W  = 8,
  parameter int DATA_OUT_W = 8,
  parameter int COEFF_W    = 8,
  parameter int LENGTH     = 32,
  parameter int LENGTH_W   = 5,
  parameter int ACC_W      = 24,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_IN_W-1:0]  data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_OUT_W-1:0] data_out,
  input  logic                         coeff_we,
  input  logic [LENGTH_W-2:0]          coeff_addr,
  input  logic signed [COEFF_W-1:0]    coeff_data,
  output logic                         coeff_ready,
`ifdef IOB_FIR_SEQ_SAT_EN
  output logic                         sat_flag,
`endif
  output logic                         busy
);

  localparam int HALF   = LENGTH / 2;
  localparam int PRE_W  = DATA_IN_W + 1;
  localparam int PROD_W = DATA_IN_W + 1 + COEFF_W;
  localparam logic [LENGTH_W-1:0] LAST_IDX = LENGTH_W'(LENGTH - 1);
  localparam logic [LENGTH_W-2:0] LAST_K   = (LENGTH_W - 1)'(HALF - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  state_t                        state_q, state_d;
  logic [LENGTH_W-1:0]           wptr_q, wptr_d;
  logic [LENGTH_W-2:0]           k_q, k_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic signed [DATA_OUT_W-1:0]  dout_q, dout_d;
  logic signed [DATA_IN_W-1:0]   smp_q [LENGTH];
  logic signed [DATA_IN_W-1:0]   smp_d [LENGTH];
  logic signed [COEFF_W-1:0]     coef_q [HALF];
  logic signed [COEFF_W-1:0]     coef_d [HALF];

  logic [LENGTH_W-1:0]           wptr_inc;
  logic [LENGTH_W-1:0]           idx_new, idx_old;
  logic signed [DATA_IN_W-1:0]   s_new, s_old;
  logic signed [PRE_W-1:0]       pre_add;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc_nxt;
  logic signed [DATA_OUT_W-1:0]  dout_res;

  // Symmetric pair: newest-k and newest-(LENGTH-1-k), wrapping naturally.
  assign wptr_inc = wptr_q + 1'b1;
  assign idx_new  = wptr_q - {1'b0, k_q};
  assign idx_old  = wptr_q - (LAST_IDX - {1'b0, k_q});
  assign s_new    = smp_q[idx_new];
  assign s_old    = smp_q[idx_old];
  assign pre_add  = PRE_W'(s_new) + PRE_W'(s_old);
  assign prod     = PROD_W'(pre_add) * PROD_W'(coef_q[k_q]);
  assign acc_nxt  = acc_q + ACC_W'(prod);

`ifdef IOB_FIR_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (DATA_OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [ACC_W-1:0] acc_shr;
  logic                    sat_hit;
  logic                    sat_q, sat_d;

  assign acc_shr = acc_nxt >>> OUT_SHIFT;

  always_comb begin
    sat_hit  = 1'b0;
    dout_res = DATA_OUT_W'(acc_shr);
    if (acc_shr > OUT_MAX) begin
      sat_hit  = 1'b1;
      dout_res = DATA_OUT_W'(OUT_MAX);
    end else if (acc_shr < OUT_MIN) begin
      sat_hit  = 1'b1;
      dout_res = DATA_OUT_W'(OUT_MIN);
    end
  end

  assign sat_flag = sat_q;
`else
  assign dout_res = acc_nxt[OUT_SHIFT +: DATA_OUT_W];
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    k_d     = k_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    smp_d   = smp_q;
    coef_d  = coef_q;
`ifdef IOB_FIR_SEQ_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (coeff_we) begin
          coef_d[coeff_addr] = coeff_data;
        end
        if (in_valid) begin
          wptr_d          = wptr_inc;
          smp_d[wptr_inc] = data_in;
          acc_d           = '0;
          k_d             = '0;
          state_d         = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_nxt;
        k_d   = k_q + 1'b1;
        if (k_q == LAST_K) begin
          dout_d  = dout_res;
          state_d = ST_OUT;
`ifdef IOB_FIR_SEQ_SAT_EN
          sat_d   = sat_q | sat_hit;
`endif
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      smp_q   <= '{default: '0};
      coef_q  <= '{default: '0};
`ifdef IOB_FIR_SEQ_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      smp_q   <= smp_d;
      coef_q  <= coef_d;
`ifdef IOB_FIR_SEQ_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign coeff_ready = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_OUT);
  assign busy        = (state_q == ST_MAC) || (state_q == ST_OUT);
  assign data_out    = dout_q;

endmodule

// File: tb/tb_iob_fir_seq.sv
// Directed bench for iob_fir_seq: impulse, backpressure, coefficient gating,
// reset abort, history wrap and output truncation/saturation.
module tb_iob_fir_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] data_out;
  logic              coeff_we;
  logic [3:0]        coeff_addr;
  logic signed [7:0] coeff_data;
  logic              coeff_ready;
  logic              busy;
`ifdef IOB_FIR_SEQ_SAT_EN
  logic              sat_flag;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  iob_fir_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .coeff_we    (coeff_we),
    .coeff_addr  (coeff_addr),
    .coeff_data  (coeff_data),
    .coeff_ready (coeff_ready),
`ifdef IOB_FIR_SEQ_SAT_EN
    .sat_flag    (sat_flag),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wcoef(input int a, input int v);
    @(negedge clk);
    coeff_we   = 1'b1;
    coeff_addr = 4'(a);
    coeff_data = 8'(v);
    @(negedge clk);
    coeff_we   = 1'b0;
  endtask

  task automatic accept(input int v, output int t_acc);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 8'(v);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    t_acc    = cyc;
  endtask

  task automatic wait_out(output int res, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) chk("out_timeout", 0, 1);
    res = int'(data_out);
  endtask

  task automatic send(input int v, output int res, output int lat, output int t_acc);
    accept(v, t_acc);
    wait_out(res, lat);
  endtask

  initial begin
    int res, lat, t0, t1, t_prev, exp_v;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    out_ready  = 1'b1;
    coeff_we   = 1'b0;
    coeff_addr = '0;
    coeff_data = '0;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_coeff_ready", int'(coeff_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_data_out", int'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // impulse: h[k]=k+1 gives 1..16 then 16..1, then 0
    for (int k = 0; k < 16; k++) wcoef(k, k + 1);
    t_prev = 0;
    for (int i = 0; i < 33; i++) begin
      send((i == 0) ? 1 : 0, res, lat, t0);
      exp_v = (i < 16) ? i + 1 : ((i < 32) ? 32 - i : 0);
      chk($sformatf("impulse_%0d", i), res, exp_v);
      if (i == 0 || i == 31) chk($sformatf("impulse_lat_%0d", i), lat, 16);
      if (i == 2) chk("impulse_period", t0 - t_prev, 18);
      t_prev = t0;
    end

    // backpressure
    do_reset();
    wcoef(0, 3);
    out_ready = 1'b0;
    send(5, res, lat, t0);
    chk("bp_result", res, 15);
    chk("bp_lat", lat, 16);
    in_valid = 1'b1;
    data_in  = 8'sd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_data", int'(data_out), 15);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_valid", int'(out_valid), 0);
    chk("bp_after_hs_ready", int'(in_ready), 1);
    chk("bp_after_hs_data", int'(data_out), 15);
    @(negedge clk);
    chk("bp_pending_accepted", int'(busy), 1);
    in_valid = 1'b0;
    wait_out(res, lat);
    chk("bp_second_result", res, 21);

    // coefficient gating
    do_reset();
    wcoef(0, 1);
    accept(4, t0);
    @(negedge clk);
    chk("cg_coeff_ready_mac", int'(coeff_ready), 0);
    coeff_we   = 1'b1;
    coeff_addr = 4'd0;
    coeff_data = 8'sd7;
    @(negedge clk);
    coeff_we = 1'b0;
    wait_out(res, lat);
    chk("cg_ignored_write", res, 4);
    @(negedge clk);
    coeff_we   = 1'b1;
    coeff_addr = 4'd0;
    coeff_data = 8'sd7;
    in_valid   = 1'b1;
    data_in    = 8'sd2;
    @(negedge clk);
    coeff_we = 1'b0;
    in_valid = 1'b0;
    wait_out(res, lat);
    chk("cg_simultaneous", res, 14);

    // reset at k=5 aborts and clears history
    accept(3, t0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_out_valid", int'(out_valid), 0);
    chk("rm_data_out", int'(data_out), 0);
    chk("rm_in_ready", int'(in_ready), 1);
    chk("rm_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wcoef(0, 1);
    send(9, res, lat, t0);
    chk("rm_cleared_buffer", res, 9);

    // wrap-around with all-ones
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(k, 1);
    for (int i = 1; i <= 40; i++) begin
      send(1, res, lat, t1);
      chk($sformatf("wrap_%0d", i), res, (i < 32) ? i : 32);
    end

    // large values: truncation or saturation
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(k, 127);
    send(127, res, lat, t0);
`ifdef IOB_FIR_SEQ_SAT_EN
    chk("big_pos_1", res, 127);
    chk("sat_flag_set", int'(sat_flag), 1);
`else
    chk("big_pos_1", res, 1);
`endif
    send(127, res, lat, t0);
`ifdef IOB_FIR_SEQ_SAT_EN
    chk("big_pos_2", res, 127);
`else
    chk("big_pos_2", res, 2);
`endif
    do_reset();
    for (int k = 0; k < 16; k++) wcoef(k, 127);
    send(-128, res, lat, t0);
    chk("big_neg", res, -128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
